izh_param_loader: RTL and testbench
===================================

// Module: izh_param_loader
// PURPOSE
//  Byte-stream configuration front end for izh_neuron_lite. Receives framed bytes from the host
//  (SPI/UART deserialiser) over a valid/ready handshake and drives param_a..d, params_ready and
//  stimulus_out. A/B/C/D writes are checksummed and committed atomically. An optional hold input
//  defers commits until the neuron is between timesteps.
// PARAMETERS
//  HDR_PARAM  8'hA5  header: 4 raw param bytes (a,b,c,d) + 1 checksum byte
//  HDR_PRESET 8'h5A  header: 1 preset-index byte
//  HDR_STIM   8'h3C  header: 1 stimulus byte
//  TIMEOUT    255    idle cycles allowed mid-frame before abort; 1..255
// PORTS
//  clk           in   1  clock
//  reset         in   1  synchronous, active-high
//  in_valid      in   1  host byte valid
//  in_data       in   8  host byte
//  in_ready      out  1  loader can accept in_data this cycle
//  cfg_hold      in   1  1 = neuron mid-step; param commits must wait
//  param_a       out  8  to neuron param_a
//  param_b       out  8  to neuron param_b
//  param_c       out  8  to neuron param_c
//  param_d       out  8  to neuron param_d
//  params_ready  out  1  to neuron params_ready; sticky after first commit
//  stimulus_out  out  8  to neuron stimulus_in
//  cfg_update    out  1  1-cycle pulse when param_a..d change
//  err_pulse     out  1  1-cycle pulse on checksum, preset-index or timeout error
//  err_count     out  8  error counter; saturates at 255
// BEHAVIOUR
//  - Byte transfer: in_valid && in_ready at a rising edge. Registered outputs only.
//  - Reset values: param_a..d = preset 0 (2,13,0,8); params_ready=0; stimulus_out=0.
//    Also cfg_update=0, err_pulse=0, err_count=0, state=IDLE.
//  - Presets (a,b,c,d): 0 RS=(2,13,0,8)  1 FS=(20,13,0,2)  2 CH=(2,13,15,2)  3 IB=(2,13,5,4).
//  - States: IDLE, PAYLOAD, CHKSUM, PRESET_IDX, STIM, PENDING.
//  - IDLE: HDR_PARAM -> PAYLOAD (idx=0, xor=0); HDR_PRESET -> PRESET_IDX; HDR_STIM -> STIM.
//    Any other byte is dropped silently; stay IDLE. This is the resync mechanism.
//  - PAYLOAD: byte idx goes to shadow[idx]; xor^=byte; idx++. After idx 3 -> CHKSUM.
//  - CHKSUM: if byte==xor, shadow is valid and moves on to commit. If not, err_pulse and -> IDLE.
//  - PRESET_IDX: index 0..3 loads the preset into shadow, then moves on to commit.
//    Index >3 gives err_pulse and -> IDLE.
//  - Commit, cfg_hold=0 on the accept edge:
//    - param_a..d <= shadow, params_ready <= 1, cfg_update <= 1, and -> IDLE, all on the same edge.
//    - New values are visible the cycle after the final byte.
//  - Commit, cfg_hold=1: -> PENDING with in_ready=0.
//    The first edge with cfg_hold=0 commits as above and -> IDLE.
//  - STIM: stimulus_out <= byte on the accept edge, -> IDLE. Never held by cfg_hold.
//    Never touches params_ready or cfg_update.
//  - in_ready = 1 in all states except PENDING (and 0 while reset asserted).
//  - Timeout: in PAYLOAD/CHKSUM/PRESET_IDX/STIM, a cycle counter counts cycles with no transfer.
//    It resets on each transfer.
//    On reaching TIMEOUT: err_pulse, -> IDLE, shadow discarded, outputs unchanged.
//    PENDING never times out.
//  - err_count += 1 per err_pulse; holds at 255.
//  - Error or timeout never alters param_a..d or params_ready (no partial updates, ever).
//  - Reset mid-frame or in PENDING: all state and outputs return to reset values;
//    any pending commit is lost.
//  - Back-to-back frames: a header may be accepted on the cycle right after a commit or STIM write.
// TESTING
//  - Reset, then idle: params=(2,13,0,8), params_ready=0, in_ready=1, err_count=0.
//  - A5,10,20,30,40,40 (xor=0x40) -> next cycle params=(10,20,30,40), cfg_update=1 for 1 cycle.
//    params_ready=1.
//  - A5,01,02,03,04,FF -> err_pulse=1, err_count=1; params unchanged; a following 3C,7F
//    gives stimulus_out=7F.
//  - cfg_hold=1, send 5A,01 -> in_ready=0, params unchanged. Drop cfg_hold ->
//    params=(20,13,0,2) and cfg_update the next cycle; in_ready=1.
//  - TIMEOUT=4: send A5,11 then stall 4 cycles -> err_pulse. Then 5A,07 -> second err_pulse.
//    err_count=2.
//  - Junk 00,FF, then A5 frame, with reset asserted after byte 3 -> all outputs at reset values.
//    A full frame afterwards commits normally.

Source files
------------

// File: rtl/izh_param_loader.sv
// ---------------------------------------------------------------------------
// izh_param_loader
//   Byte-stream configuration front end for izh_neuron_lite. Framed bytes
//   arrive over a valid/ready handshake. The loader decodes three frame types.
//     - Parameter frame: header, a, b, c, d, checksum. The checksum is the XOR
//       of the four payload bytes.
//     - Preset frame: header, then a preset index.
//     - Stimulus frame: header, then a stimulus byte.
//   The four neuron parameters are committed together, or not at all. While
//   cfg_hold is high, a commit is parked until the neuron is between
//   timesteps.
//
// Ports
//   clk, reset      clock; synchronous active-high reset
//   in_valid/in_data/in_ready   host byte handshake (transfer = valid && ready)
//   cfg_hold        1 = neuron mid-step, parameter commits must wait
//   param_a..d      committed neuron parameters
//   params_ready    sticky, set by the first commit
//   stimulus_out    last stimulus byte received
//   cfg_update      1-cycle pulse when param_a..d are written
//   err_pulse       1-cycle pulse on checksum, preset-index or timeout error
//   err_count       saturating error counter
// ---------------------------------------------------------------------------
module izh_param_loader #(
    parameter logic [7:0] HDR_PARAM  = 8'hA5,
    parameter logic [7:0] HDR_PRESET = 8'h5A,
    parameter logic [7:0] HDR_STIM   = 8'h3C,
    parameter int         TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    input  logic       cfg_hold,
    output logic [7:0] param_a,
    output logic [7:0] param_b,
    output logic [7:0] param_c,
    output logic [7:0] param_d,
    output logic       params_ready,
    output logic [7:0] stimulus_out,
    output logic       cfg_update,
    output logic       err_pulse,
    output logic [7:0] err_count
);

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PAYLOAD    = 3'd1,
        ST_CHKSUM     = 3'd2,
        ST_PRESET_IDX = 3'd3,
        ST_STIM       = 3'd4,
        ST_PENDING    = 3'd5
    } state_t;

    // The idle counter aborts a frame on the edge where it has already seen
    // TIMEOUT-1 idle cycles and a further idle cycle occurs.
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);
    localparam logic [31:0] PRESET_RS = {8'd2, 8'd13, 8'd0, 8'd8};

    // The preset table is packed as {a, b, c, d}.
    function automatic logic [31:0] preset_lookup(input logic [1:0] idx);
        logic [31:0] vals;
        case (idx)
            2'd0:    vals = PRESET_RS;
            2'd1:    vals = {8'd20, 8'd13, 8'd0,  8'd2};
            2'd2:    vals = {8'd2,  8'd13, 8'd15, 8'd2};
            2'd3:    vals = {8'd2,  8'd13, 8'd5,  8'd4};
            default: vals = PRESET_RS;
        endcase
        return vals;
    endfunction

    state_t      state_r;
    logic [31:0] shadow_r;        // {a,b,c,d}, assembled by shifting in payload bytes
    logic [7:0]  xor_r;
    logic [1:0]  idx_r;
    logic [7:0]  idle_cnt_r;
    logic [31:0] params_r;
    logic        params_ready_r;
    logic [7:0]  stimulus_r;
    logic        cfg_update_r;
    logic        err_pulse_r;
    logic [7:0]  err_count_r;

    logic        xfer_s;
    logic        in_frame_s;
    logic        timeout_s;
    logic        load_s;
    logic        bad_s;
    logic        err_s;
    logic        commit_s;
    logic [31:0] load_vals_s;
    logic [31:0] commit_vals_s;

    // PENDING is the only state that refuses bytes.
    assign in_ready = !reset && (state_r != ST_PENDING);

    // Decode transfers, frame completion, errors and the values to commit.
    always_comb begin
        xfer_s        = in_valid && in_ready;
        in_frame_s    = 1'b0;
        load_s        = 1'b0;
        bad_s         = 1'b0;
        load_vals_s   = shadow_r;
        commit_vals_s = shadow_r;
        case (state_r)
            ST_PAYLOAD, ST_STIM: begin
                in_frame_s = 1'b1;
            end
            ST_CHKSUM: begin
                in_frame_s = 1'b1;
                if (in_data == xor_r) begin
                    load_s = xfer_s;
                end else begin
                    bad_s = xfer_s;
                end
            end
            ST_PRESET_IDX: begin
                in_frame_s  = 1'b1;
                load_vals_s = preset_lookup(in_data[1:0]);
                if (in_data <= 8'd3) begin
                    load_s = xfer_s;
                end else begin
                    bad_s = xfer_s;
                end
            end
            default: begin
                in_frame_s = 1'b0;
            end
        endcase
        timeout_s = in_frame_s && !xfer_s && (idle_cnt_r == TIMEOUT_LAST);
        err_s     = bad_s || timeout_s;
        if (state_r == ST_PENDING) begin
            commit_s      = !cfg_hold;
            commit_vals_s = shadow_r;
        end else begin
            commit_s      = load_s && !cfg_hold;
            commit_vals_s = load_vals_s;
        end
    end

    // The frame FSM, the commit datapath and the error bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            shadow_r       <= 32'h0000_0000;
            xor_r          <= 8'h00;
            idx_r          <= 2'd0;
            idle_cnt_r     <= 8'h00;
            params_r       <= PRESET_RS;
            params_ready_r <= 1'b0;
            stimulus_r     <= 8'h00;
            cfg_update_r   <= 1'b0;
            err_pulse_r    <= 1'b0;
            err_count_r    <= 8'h00;
        end else begin
            err_pulse_r <= err_s;
            if (err_s && (err_count_r != 8'hFF)) begin
                err_count_r <= err_count_r + 8'd1;
            end else begin
                err_count_r <= err_count_r;
            end

            if (commit_s) begin
                params_r       <= commit_vals_s;
                params_ready_r <= 1'b1;
                cfg_update_r   <= 1'b1;
            end else begin
                cfg_update_r   <= 1'b0;
            end

            // Counts consecutive idle cycles only while a frame is open.
            if (xfer_s || !in_frame_s) begin
                idle_cnt_r <= 8'h00;
            end else begin
                idle_cnt_r <= idle_cnt_r + 8'd1;
            end

            case (state_r)
                ST_IDLE: begin
                    if (xfer_s) begin
                        case (in_data)
                            HDR_PARAM: begin
                                state_r <= ST_PAYLOAD;
                                idx_r   <= 2'd0;
                                xor_r   <= 8'h00;
                            end
                            HDR_PRESET: state_r <= ST_PRESET_IDX;
                            HDR_STIM:   state_r <= ST_STIM;
                            default:    state_r <= ST_IDLE;   // resync: drop junk
                        endcase
                    end
                end
                ST_PAYLOAD: begin
                    if (xfer_s) begin
                        shadow_r <= {shadow_r[23:0], in_data};
                        xor_r    <= xor_r ^ in_data;
                        idx_r    <= idx_r + 2'd1;
                        if (idx_r == 2'd3) begin
                            state_r <= ST_CHKSUM;
                        end else begin
                            state_r <= ST_PAYLOAD;
                        end
                    end else if (timeout_s) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_PAYLOAD;
                    end
                end
                ST_CHKSUM, ST_PRESET_IDX: begin
                    if (load_s && cfg_hold) begin
                        shadow_r <= load_vals_s;
                        state_r  <= ST_PENDING;
                    end else if (xfer_s || timeout_s) begin
                        state_r  <= ST_IDLE;
                    end else begin
                        state_r  <= state_r;
                    end
                end
                ST_STIM: begin
                    if (xfer_s) begin
                        stimulus_r <= in_data;
                        state_r    <= ST_IDLE;
                    end else if (timeout_s) begin
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r    <= ST_STIM;
                    end
                end
                ST_PENDING: begin
                    if (!cfg_hold) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_PENDING;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
        end
    end

    assign param_a      = params_r[31:24];
    assign param_b      = params_r[23:16];
    assign param_c      = params_r[15:8];
    assign param_d      = params_r[7:0];
    assign params_ready = params_ready_r;
    assign stimulus_out = stimulus_r;
    assign cfg_update   = cfg_update_r;
    assign err_pulse    = err_pulse_r;
    assign err_count    = err_count_r;

endmodule

// File: tb/tb_izh_param_loader.sv
// Self-checking bench for izh_param_loader. It runs directed frames and then
// random frames. A frame-level reference model tracks every accepted byte,
// and all DUT outputs are compared against the model after every edge.
module tb_izh_param_loader;

    localparam int TMO = 4;
    localparam int M_IDLE = 0, M_PARAM = 1, M_PRESET = 2, M_STIM = 3, M_PEND = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       cfg_hold = 1'b0;
    logic [7:0] param_a, param_b, param_c, param_d;
    logic       params_ready;
    logic [7:0] stimulus_out;
    logic       cfg_update;
    logic       err_pulse;
    logic [7:0] err_count;

    int n_checks = 0;
    int n_errors = 0;
    int hold_rate = 0;

    // reference model state
    int          m_mode = M_IDLE;
    int          m_gap = 0;
    logic [7:0]  m_q[$];
    logic [31:0] m_params = 32'h020D0008;
    logic [31:0] m_pend = 32'h0;
    logic        m_prdy = 1'b0;
    logic [7:0]  m_stim = 8'h00;
    logic        m_upd = 1'b0;
    logic        m_err = 1'b0;
    int          m_cnt = 0;

    izh_param_loader #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .cfg_hold(cfg_hold),
        .param_a(param_a), .param_b(param_b), .param_c(param_c), .param_d(param_d),
        .params_ready(params_ready), .stimulus_out(stimulus_out),
        .cfg_update(cfg_update), .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] preset_of(input logic [7:0] i);
        case (i)
            8'd0:    return {8'd2,  8'd13, 8'd0,  8'd8};
            8'd1:    return {8'd20, 8'd13, 8'd0,  8'd2};
            8'd2:    return {8'd2,  8'd13, 8'd15, 8'd2};
            default: return {8'd2,  8'd13, 8'd5,  8'd4};
        endcase
    endfunction

    task automatic m_apply(input logic [31:0] vals);
        m_params = vals; m_prdy = 1'b1; m_upd = 1'b1; m_mode = M_IDLE;
    endtask

    task automatic m_settle(input logic [31:0] vals, input logic h);
        if (h) begin m_pend = vals; m_mode = M_PEND; end
        else m_apply(vals);
    endtask

    task automatic m_fail();
        m_err = 1'b1;
        if (m_cnt < 255) m_cnt++;
        m_mode = M_IDLE;
    endtask

    // Frame-level behaviour at one rising edge.
    task automatic model_edge(input logic v, input logic [7:0] d, input logic h, input logic r);
        logic xfer;
        if (r) begin
            m_params = 32'h020D0008; m_prdy = 1'b0; m_stim = 8'h00; m_upd = 1'b0;
            m_err = 1'b0; m_cnt = 0; m_mode = M_IDLE; m_q.delete(); m_gap = 0;
        end else begin
            m_upd = 1'b0; m_err = 1'b0;
            xfer = v && (m_mode != M_PEND);
            if (m_mode == M_IDLE) begin
                if (xfer) begin
                    m_q.delete(); m_gap = 0;
                    if (d == 8'hA5) m_mode = M_PARAM;
                    else if (d == 8'h5A) m_mode = M_PRESET;
                    else if (d == 8'h3C) m_mode = M_STIM;
                end
            end else if (m_mode == M_PEND) begin
                if (!h) m_apply(m_pend);
            end else if (xfer) begin
                m_gap = 0;
                m_q.push_back(d);
                if (m_mode == M_STIM) begin
                    m_stim = d; m_mode = M_IDLE;
                end else if (m_mode == M_PRESET) begin
                    if (d < 8'd4) m_settle(preset_of(d), h);
                    else m_fail();
                end else if (m_q.size() == 5) begin
                    if ((m_q[0] ^ m_q[1] ^ m_q[2] ^ m_q[3]) == m_q[4])
                        m_settle({m_q[0], m_q[1], m_q[2], m_q[3]}, h);
                    else m_fail();
                end
            end else begin
                m_gap++;
                if (m_gap >= TMO) m_fail();
            end
        end
    endtask

    // One clock cycle: drive, check ready, clock, update model, check outputs.
    task automatic step(input logic v, input logic [7:0] d, input logic h, input logic r,
                        output logic acc);
        in_valid = v; in_data = d; cfg_hold = h; reset = r;
        #1;
        check_val("in_ready", {31'd0, in_ready}, {31'd0, (!r && m_mode != M_PEND)});
        acc = v && in_ready && !r;
        @(posedge clk);
        model_edge(v, d, h, r);
        #1;
        check_val("params", {param_a, param_b, param_c, param_d}, m_params);
        check_val("params_ready", {31'd0, params_ready}, {31'd0, m_prdy});
        check_val("stimulus_out", {24'd0, stimulus_out}, {24'd0, m_stim});
        check_val("cfg_update", {31'd0, cfg_update}, {31'd0, m_upd});
        check_val("err_pulse", {31'd0, err_pulse}, {31'd0, m_err});
        check_val("err_count", {24'd0, err_count}, m_cnt);
    endtask

    function automatic logic hold_fn();
        return ($urandom_range(0, 99) < hold_rate);
    endfunction

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'($urandom), hold_fn(), 1'b0, acc);
    endtask

    task automatic do_reset(input int n);
        logic acc;
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b1, acc);
    endtask

    // Offers a byte until it is accepted, with a bounded wait.
    task automatic send_byte(input logic [7:0] d);
        logic acc;
        int   tries;
        acc = 1'b0; tries = 0;
        while (!acc && tries < 40) begin
            step(1'b1, d, hold_fn(), 1'b0, acc);
            tries++;
        end
        check_val("send_accept", {31'd0, acc}, 32'd1);
    endtask

    task automatic send_seq(input logic [7:0] b[]);
        foreach (b[i]) send_byte(b[i]);
    endtask

    function automatic int gap_fn();
        int r;
        r = $urandom_range(0, 19);
        if (r < 14) return 0;
        else if (r < 18) return $urandom_range(1, 2);
        else return $urandom_range(3, 5);
    endfunction

    task automatic send_gapped(input logic [7:0] d);
        idle(gap_fn());
        send_byte(d);
    endtask

    initial begin
        logic [7:0] b[4];
        logic [7:0] cs;
        int kind;

        // reset, then idle
        do_reset(3);
        idle(2);
        check_val("t0_params", {param_a, param_b, param_c, param_d}, 32'h020D0008);
        check_val("t0_prdy", {31'd0, params_ready}, 32'd0);
        check_val("t0_ready", {31'd0, in_ready}, 32'd1);
        check_val("t0_errcnt", {24'd0, err_count}, 32'd0);

        // good parameter frame
        send_seq('{8'hA5, 8'h10, 8'h20, 8'h30, 8'h40, 8'h40});
        check_val("t1_params", {param_a, param_b, param_c, param_d}, 32'h10203040);
        check_val("t1_update", {31'd0, cfg_update}, 32'd1);
        check_val("t1_prdy", {31'd0, params_ready}, 32'd1);
        idle(1);
        check_val("t1_update_pulse", {31'd0, cfg_update}, 32'd0);

        // bad checksum, then a stimulus frame
        send_seq('{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF});
        check_val("t2_err", {31'd0, err_pulse}, 32'd1);
        check_val("t2_errcnt", {24'd0, err_count}, 32'd1);
        check_val("t2_params", {param_a, param_b, param_c, param_d}, 32'h10203040);
        send_seq('{8'h3C, 8'h7F});
        check_val("t2_stim", {24'd0, stimulus_out}, 32'h7F);

        // preset frame while cfg_hold is high
        hold_rate = 100;
        send_seq('{8'h5A, 8'h01});
        idle(1);
        check_val("t3_ready_held", {31'd0, in_ready}, 32'd0);
        check_val("t3_params_held", {param_a, param_b, param_c, param_d}, 32'h10203040);
        hold_rate = 0;
        idle(1);
        check_val("t3_params", {param_a, param_b, param_c, param_d}, 32'h140D0002);
        check_val("t3_update", {31'd0, cfg_update}, 32'd1);
        check_val("t3_ready", {31'd0, in_ready}, 32'd1);

        // timeout, then a bad preset index
        do_reset(1);
        send_seq('{8'hA5, 8'h11});
        idle(3);
        check_val("t4_no_err_yet", {31'd0, err_pulse}, 32'd0);
        idle(1);
        check_val("t4_timeout", {31'd0, err_pulse}, 32'd1);
        send_seq('{8'h5A, 8'h07});
        check_val("t4_idx_err", {31'd0, err_pulse}, 32'd1);
        check_val("t4_errcnt", {24'd0, err_count}, 32'd2);

        // junk bytes, a partial frame, then reset
        send_seq('{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h02});
        do_reset(1);
        check_val("t5_params", {param_a, param_b, param_c, param_d}, 32'h020D0008);
        check_val("t5_prdy", {31'd0, params_ready}, 32'd0);
        check_val("t5_stim", {24'd0, stimulus_out}, 32'd0);
        check_val("t5_errcnt", {24'd0, err_count}, 32'd0);
        send_seq('{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h04});
        check_val("t5_commit", {param_a, param_b, param_c, param_d}, 32'h01020304);

        // random frames against the model
        for (int it = 0; it < 400; it++) begin
            kind = $urandom_range(0, 6);
            hold_rate = ($urandom_range(0, 3) == 0) ? 60 : 0;
            case (kind)
                0, 1: begin
                    send_gapped(8'hA5);
                    cs = 8'h00;
                    for (int i = 0; i < 4; i++) begin
                        b[i] = 8'($urandom);
                        cs = cs ^ b[i];
                        send_gapped(b[i]);
                    end
                    if (kind == 1) cs = cs ^ 8'($urandom_range(1, 255));
                    send_gapped(cs);
                end
                2: begin send_gapped(8'h5A); send_gapped(8'($urandom_range(0, 5))); end
                3: begin send_gapped(8'h3C); send_gapped(8'($urandom)); end
                4: send_gapped(8'($urandom));
                5: begin send_byte(8'hA5); send_byte(8'($urandom)); idle(5); end
                default: begin
                    if ($urandom_range(0, 3) == 0) do_reset(1);
                    else idle(1);
                end
            endcase
        end
        hold_rate = 0;
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
